scroll_controller: RTL and testbench

SCROLL_CONTROLLER -- requirements
Module: scroll_controller

---
 rtl/scroll_controller.sv | 105 ++++++++++
 tb/tb_scroll_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_controller.sv
// Vertical camera controller: follows the doodle upward past a scroll line and
// flags a fall below the screen bottom.
module scroll_controller #(
    parameter int COORD_W       = 32,
    parameter int SCREEN_HEIGHT = 700,
    parameter int SCROLL_LINE   = 350,
    parameter int MAX_STEP      = 8,
    parameter int SMOOTH        = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] doodle_y,
    output logic [COORD_W-1:0] cam_y,
    output logic [COORD_W-1:0] scroll_amt,
    output logic               new_view,
    output logic               min_y_crossed,
    output logic [1:0]         state
);

    localparam int W1 = COORD_W + 1;
    localparam logic [COORD_W:0] CAP  = {1'b0, {COORD_W{1'b1}}} - W1'(SCREEN_HEIGHT);
    localparam logic [COORD_W:0] LINE = W1'(SCROLL_LINE);
    localparam logic [COORD_W:0] MAXS = W1'(MAX_STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SCROLL = 2'd2,
        OVER   = 2'd3
    } stateT;

    stateT            stateQ;
    logic [COORD_W:0] lineY;
    logic [COORD_W:0] diff;
    logic [COORD_W:0] rawStep;
    logic [COORD_W:0] room;
    logic [COORD_W:0] step;
    logic             above;
    logic             longJump;
    logic             fell;

    assign state = stateQ;

    // One extra bit keeps cam_y + SCROLL_LINE from wrapping near the top of the range.
    always_comb begin
        lineY    = {1'b0, cam_y} + LINE;
        above    = {1'b0, doodle_y} > lineY;
        diff     = above ? ({1'b0, doodle_y} - lineY) : '0;
        longJump = (SMOOTH != 0) && (diff > MAXS);
        rawStep  = longJump ? MAXS : diff;
        room     = CAP - {1'b0, cam_y};
        step     = (rawStep > room) ? room : rawStep;
        fell     = doodle_y < cam_y;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ        <= IDLE;
            cam_y         <= '0;
            scroll_amt    <= '0;
            new_view      <= 1'b0;
            min_y_crossed <= 1'b0;
        end else begin
            new_view <= 1'b0;
            if (start) begin
                stateQ        <= RUN;
                cam_y         <= '0;
                scroll_amt    <= '0;
                min_y_crossed <= 1'b0;
            end else begin
                case (stateQ)
                    RUN: begin
                        if (frame_tick) begin
                            if (fell) begin
                                stateQ        <= OVER;
                                min_y_crossed <= 1'b1;
                            end else if (above) begin
                                if (step != '0) begin
                                    cam_y      <= cam_y + step[COORD_W-1:0];
                                    scroll_amt <= step[COORD_W-1:0];
                                    new_view   <= 1'b1;
                                end
                                stateQ <= longJump ? SCROLL : RUN;
                            end
                        end
                    end
                    SCROLL: begin
                        // At the cap the step clips to zero while the distance stays large,
                        // so the camera parks here until a restart.
                        if (above && step != '0) begin
                            cam_y      <= cam_y + step[COORD_W-1:0];
                            scroll_amt <= step[COORD_W-1:0];
                            new_view   <= 1'b1;
                        end
                        stateQ <= (above && longJump) ? SCROLL : RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scroll_controller.sv
// Randomized and directed bench for scroll_controller, checked against a
// behavioural model of the camera rules across three parameterisations.
module tb_scroll_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        frame_tick = 1'b0;
    logic [31:0] doodle = '0;

    logic [31:0] cam0, amt0, cam1, amt1;
    logic [9:0]  cam2, amt2;
    logic        nv0, nv1, nv2, fl0, fl1, fl2;
    logic [1:0]  st0, st1, st2;

    int nCmp = 0;
    int nErr = 0;
    bit liveCheck = 1'b1;

    always #5 clk = ~clk;

    scroll_controller #(.COORD_W(32), .SMOOTH(1)) dutSmooth (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick), .doodle_y(doodle),
        .cam_y(cam0), .scroll_amt(amt0), .new_view(nv0), .min_y_crossed(fl0), .state(st0));

    scroll_controller #(.COORD_W(32), .SMOOTH(0)) dutSnap (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick), .doodle_y(doodle),
        .cam_y(cam1), .scroll_amt(amt1), .new_view(nv1), .min_y_crossed(fl1), .state(st1));

    scroll_controller #(.COORD_W(10), .SMOOTH(1)) dutNarrow (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick), .doodle_y(doodle[9:0]),
        .cam_y(cam2), .scroll_amt(amt2), .new_view(nv2), .min_y_crossed(fl2), .state(st2));

    // Behavioural model: state numbering follows the required output encoding.
    typedef struct {
        longint cam;
        longint amt;
        bit     nv;
        bit     flag;
        int     st;
    } mdlT;

    mdlT m[3];

    function automatic int widthOf(int k);
        return (k == 2) ? 10 : 32;
    endfunction

    function automatic bit smoothOf(int k);
        return (k != 1);
    endfunction

    function automatic mdlT advance(mdlT c, int k, longint d);
        mdlT    n = c;
        longint cap = (longint'(1) << widthOf(k)) - 1 - 700;
        longint diff, stp;
        if (d > c.cam + 350) begin
            diff = d - c.cam - 350;
            stp  = (smoothOf(k) && diff > 8) ? 8 : diff;
            if (stp > cap - c.cam) stp = cap - c.cam;
            if (stp > 0) begin
                n.cam = c.cam + stp;
                n.amt = stp;
                n.nv  = 1'b1;
            end
            n.st = (smoothOf(k) && diff > 8) ? 2 : 1;
        end else begin
            n.st = 1;
        end
        return n;
    endfunction

    function automatic mdlT nextOf(mdlT c, int k, bit s, bit t, longint dFull);
        mdlT    n = c;
        longint d = dFull & ((longint'(1) << widthOf(k)) - 1);
        n.nv = 1'b0;
        if (s) begin
            n.cam = 0; n.amt = 0; n.flag = 1'b0; n.st = 1;
        end else if (c.st == 1 && t) begin
            if (d < c.cam) begin
                n.st = 3; n.flag = 1'b1;
            end else begin
                n = advance(n, k, d);
            end
        end else if (c.st == 2) begin
            n = advance(n, k, d);
        end
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset) m[k] <= '{cam: 0, amt: 0, nv: 1'b0, flag: 1'b0, st: 0};
            else        m[k] <= nextOf(m[k], k, start, frame_tick, longint'(doodle));
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        nCmp++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmpInst(input int k, input longint cam, input longint amt, input bit nv,
                           input bit fl, input int st);
        chk($sformatf("u%0d.cam_y", k), cam, m[k].cam);
        chk($sformatf("u%0d.scroll_amt", k), amt, m[k].amt);
        chk($sformatf("u%0d.new_view", k), longint'(nv), longint'(m[k].nv));
        chk($sformatf("u%0d.min_y_crossed", k), longint'(fl), longint'(m[k].flag));
        chk($sformatf("u%0d.state", k), longint'(st), longint'(m[k].st));
    endtask

    always @(negedge clk) begin
        if (liveCheck) begin
            cmpInst(0, longint'(cam0), longint'(amt0), nv0, fl0, int'(st0));
            cmpInst(1, longint'(cam1), longint'(amt1), nv1, fl1, int'(st1));
            cmpInst(2, longint'(cam2), longint'(amt2), nv2, fl2, int'(st2));
        end
    end

    // One clock: inputs applied after a falling edge, strobes cleared just after the rising edge.
    task automatic cyc(input bit s, input bit t, input logic [31:0] y);
        @(negedge clk);
        #1;
        start = s; frame_tick = t; doodle = y;
        @(posedge clk);
        #1;
        start = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, doodle);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #23 reset = 1'b1;
        chk("reset.state", longint'(st0), 0);
        chk("reset.cam_y", longint'(cam0), 0);

        cyc(0, 1, 300);
        chk("idle.ignores_tick", longint'(st0), 0);
        cyc(1, 0, 300);
        chk("start.state", longint'(st0), 1);
        cyc(0, 1, 300);
        chk("below_line.new_view", longint'(nv0), 0);
        chk("below_line.cam_y", longint'(cam0), 0);

        cyc(0, 1, 355);
        chk("small.cam_y", longint'(cam0), 5);
        chk("small.scroll_amt", longint'(amt0), 5);
        chk("small.new_view", longint'(nv0), 1);
        chk("small.state", longint'(st0), 1);
        idleCycles(1);
        chk("small.pulse_len", longint'(nv0), 0);

        cyc(1, 0, 370);
        cyc(0, 1, 370);
        chk("smooth.cam_1", longint'(cam0), 8);
        chk("smooth.state_1", longint'(st0), 2);
        chk("snap.cam_1", longint'(cam1), 20);
        idleCycles(1);
        chk("smooth.cam_2", longint'(cam0), 16);
        chk("smooth.nv_2", longint'(nv0), 1);
        idleCycles(1);
        chk("smooth.cam_3", longint'(cam0), 20);
        chk("smooth.amt_3", longint'(amt0), 4);
        chk("smooth.state_3", longint'(st0), 1);
        idleCycles(1);
        chk("smooth.nv_end", longint'(nv0), 0);

        cyc(1, 0, 1000);
        cyc(0, 1, 1000);
        chk("snap.cam_650", longint'(cam1), 650);
        chk("snap.nv", longint'(nv1), 1);
        chk("snap.state", longint'(st1), 1);

        cyc(1, 0, 450);
        cyc(0, 1, 450);
        idleCycles(14);
        chk("fall.setup_cam", longint'(cam0), 100);
        cyc(0, 1, 99);
        chk("fall.state", longint'(st0), 3);
        chk("fall.flag", longint'(fl0), 1);
        chk("fall.cam_held", longint'(cam0), 100);
        cyc(0, 1, 600);
        chk("over.tick_ignored", longint'(cam0), 100);
        cyc(1, 0, 99);
        chk("restart.cam", longint'(cam0), 0);
        chk("restart.flag", longint'(fl0), 0);
        chk("restart.state", longint'(st0), 1);

        cyc(0, 1, 500);
        idleCycles(1);
        chk("mid_scroll.state", longint'(st0), 2);
        #2 reset = 1'b0;
        #1;
        chk("async_reset.cam", longint'(cam0), 0);
        chk("async_reset.amt", longint'(amt0), 0);
        chk("async_reset.state", longint'(st0), 0);
        #3 reset = 1'b1;
        cyc(1, 1, 500);
        chk("start_vs_tick.cam", longint'(cam0), 0);
        chk("start_vs_tick.nv", longint'(nv0), 0);
        chk("start_vs_tick.state", longint'(st0), 1);

        cyc(0, 1, 1023);
        idleCycles(50);
        chk("cap.cam", longint'(cam2), 323);
        chk("cap.nv", longint'(nv2), 0);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            start      = ($urandom_range(0, 99) < 2);
            frame_tick = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 9) < 7)
                doodle = 32'(m[0].cam + $urandom_range(0, 440) >= 20 ?
                              m[0].cam + $urandom_range(0, 440) - 20 : 0);
            else
                doodle = $urandom_range(0, 1100);
            if ($urandom_range(0, 199) == 0) begin
                #1 reset = 1'b0;
                #2 reset = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        start = 1'b0; frame_tick = 1'b0;
        @(negedge clk);
        liveCheck = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
